// File: rtl/hft_pkg.sv
// Shared types and constants for the trade report framing path.
package hft_pkg;
  typedef enum logic [2:0] {IDLE, HDR, BODY, TSTAMP, CSUM} frame_state_t;

  localparam int          FRAME_WORDS      = 4;
  localparam logic [7:0]  LEN_FIELD        = 8'h04;
  localparam logic [7:0]  DEFAULT_MSG_TYPE = 8'hA5;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] ts;
  } fifo_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and a registered occupancy count.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/trade_report_framer.sv
// Buffers approved trades and emits each as a 4-word frame: header, trade, timestamp, XOR checksum.
module trade_report_framer
  import hft_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  MSG_TYPE   = DEFAULT_MSG_TYPE,
  parameter logic [15:0] SEQ_INIT   = 16'h0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   trade_data,
  input  logic                          trade_valid,
  input  logic                          trade_approved,
  output logic [31:0]                   tx_data,
  output logic                          tx_valid,
  output logic                          tx_last,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic [15:0]                   seq_num,
  output logic                          busy
);
  frame_state_t state;
  fifo_entry_t  wr_entry;
  fifo_entry_t  rd_entry;
  logic [31:0]  ts;
  logic [31:0]  lat_data;
  logic [31:0]  lat_ts;
  logic [31:0]  hdr_word;
  logic [31:0]  next_hdr;
  logic         qualified;
  logic         fifo_full;
  logic         fifo_empty;
  logic         take;
  logic         pop;

  function automatic logic [31:0] frame_csum(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2);
    return w0 ^ w1 ^ w2;
  endfunction

  assign qualified = trade_valid && trade_approved;
  assign wr_entry  = '{data: trade_data, ts: ts};
  assign take      = tx_valid && tx_ready;
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == CSUM) && take));
  // A pop from CSUM starts the following frame, whose sequence number is one ahead.
  assign next_hdr  = {MSG_TYPE, LEN_FIELD, (state == CSUM) ? seq_num + 16'd1 : seq_num};
  assign busy      = (state != IDLE);

  sync_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (qualified),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                              drop_count <= '0;
    else if (qualified && fifo_full && drop_count != '1)  drop_count <= drop_count + 16'd1;
  end

  // Capture stage: head entry and header word frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (pop) begin
      lat_data <= rd_entry.data;
      lat_ts   <= rd_entry.ts;
      hdr_word <= next_hdr;
    end
  end

  // Output stage: one registered word per state, advanced only on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_data  <= '0;
      seq_num  <= SEQ_INIT;
    end else begin
      case (state)
        IDLE: if (pop) begin
          tx_data  <= next_hdr;
          tx_valid <= 1'b1;
          state    <= HDR;
        end
        HDR: if (take) begin
          tx_data <= lat_data;
          state   <= BODY;
        end
        BODY: if (take) begin
          tx_data <= lat_ts;
          state   <= TSTAMP;
        end
        TSTAMP: if (take) begin
          tx_data <= frame_csum(hdr_word, lat_data, lat_ts);
          tx_last <= 1'b1;
          state   <= CSUM;
        end
        CSUM: if (take) begin
          seq_num <= seq_num + 16'd1;
          tx_last <= 1'b0;
          if (pop) begin
            tx_data <= next_hdr;
            state   <= HDR;
          end else begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/trade_report_framer.md
# trade_report_framer

Downstream of the order matching engine and risk check, this block turns each approved trade into a 4-word report frame. It sends the frame on the 32-bit application TX stream toward the TCP layer. Trades arrive as single-cycle pulses with no backpressure, so they are buffered in a small FIFO. Each frame is stamped with a sequence number and a capture timestamp and closed with an XOR checksum. Overflow drops are counted and never stall the trade path.

## Interface
- FIFO_DEPTH, 8: trade buffer entries; power of two, at least 2.
- MSG_TYPE, 8'hA5: message type byte placed in the header word.
- clk  in  1: sole clock; all logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- trade_data  in  32: trade word from the matching engine.
- trade_valid  in  1: single-cycle trade strobe.
- trade_approved  in  1: risk approval, qualified with trade_valid.
- tx_data  out  32: frame word toward the TCP layer app_tx.
- tx_valid  out  1: tx_data is valid.
- tx_last  out  1: marks the final (checksum) word of a frame.
- tx_ready  in  1: downstream accepts the word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1: number of buffered trades.
- drop_count  out  16: trades lost to overflow; saturates.
- seq_num  out  16: sequence number of the next frame.
- busy  out  1: high in any state other than IDLE.

## Operation
- Push: a trade is pushed when trade_valid && trade_approved and the FIFO is not full. Each entry is {trade_data, ts} (64 bits).
- ts is a free-running 32-bit cycle counter. It is 0 in the first cycle after reset and wraps 32'hFFFFFFFF -> 0.
- Overflow: a qualified trade arriving while the FIFO is full is dropped and drop_count increments. Full is judged on the registered count, so the trade is dropped even if a pop occurs in the same cycle. drop_count saturates at 16'hFFFF.
- An unapproved trade is ignored: no push and no count.
- FSM states are IDLE, HDR, BODY, TSTAMP, CSUM.
  - IDLE: when the FIFO is not empty, pop the head, latch it, and go to HDR.
  - HDR drives W0 = {MSG_TYPE, 8'h04, seq_num}.
  - BODY drives W1 = the latched trade_data.
  - TSTAMP drives W2 = the latched ts.
  - CSUM drives W3 = W0 ^ W1 ^ W2 with tx_last = 1.
  - Each state advances only on tx_valid && tx_ready.
- After the CSUM handshake, seq_num increments (16'hFFFF wraps to 0). The FSM then returns to IDLE, or goes straight to HDR with a new pop if the FIFO is still non-empty.
- Checksum width: a 32-bit bitwise XOR. The checksum is computed from the latched words and carries no dependence on live inputs.
- Simultaneous push and pop: fifo_level stays unchanged.

## Timing
- Reset values:
  - tx_valid = 0, tx_last = 0, tx_data = 0
  - fifo_level = 0, drop_count = 0, seq_num = 0
  - busy = 0, FSM in IDLE, ts = 0
- Latency: a qualified trade sampled at edge N while IDLE with an empty FIFO gives tx_valid = 1 with W0 in the cycle after edge N+1 (2 cycles).
- Throughput: at most one word per cycle. With tx_ready held at 1, a frame takes 4 cycles. Back-to-back frames have no idle cycle between W3 and the next W0.
- Stall rule: while tx_valid && !tx_ready, tx_data and tx_last hold stable and tx_valid stays high.
- tx_valid never drops mid-frame except on rst.
- Reset mid-frame: the frame is abandoned, tx_valid = 0 in the cycle after rst is sampled, the FIFO is flushed, and seq_num returns to 0. No partial-frame recovery.

## Structure
- Shared package hft_pkg holds:
  - the FSM state enum (frame_state_t),
  - FRAME_WORDS = 4,
  - LEN_FIELD = 8'h04,
  - DEFAULT_MSG_TYPE = 8'hA5,
  - the 64-bit fifo entry struct.
- Sub-module sync_fifo (parameterised WIDTH and DEPTH, registered count, full/empty flags) carries the buffering. The framer holds the FSM, the ts counter, the sequence number, drop_count and the checksum.

## Test plan
- Single frame: reset, then 16 cycles later send trade_data = 32'h12345678 (approved) with tx_ready = 1. Expect W0 = A5040000, W1 = 12345678, W2 = 00000010, W3 = B7305668 with tx_last = 1, then seq_num = 1.
- Backpressure: the same trade with tx_ready low for 5 cycles on each word. Expect every word held stable and the same 4 values in order, with no duplicates.
- Overflow: hold tx_ready = 0 and send 10 approved trades back-to-back. Expect fifo_level = 8 and drop_count = 1. The first trade is already popped into the framer, so 9 are stored and the 10th is dropped. Then release tx_ready and expect 9 frames with seq_num 0..8.
- Unapproved trade: trade_valid = 1 with trade_approved = 0. Expect no frame and no change to fifo_level or drop_count.
- Sequence wrap: force 65536 frames (or preload seq_num via a bench hook). Expect header seq field 16'hFFFF followed by 16'h0000.
- Reset mid-frame: assert rst after the W1 handshake. Expect tx_valid = 0 in the next cycle, fifo_level = 0, seq_num = 0, and the next trade framed with seq 0.
